host_cmd_decoder: RTL
=====================

Name: host_cmd_decoder

Overview:
- Parses byte frames from the host-PC serial link (UART RX byte stream) into a bank of 32-bit control registers.
- Register 0 drives the select/control input of the downstream switch stage. Registers 1..NUM_REGS-1 are spare controls.
- Validates each frame by header and checksum. Flags malformed or stalled frames.

Parameters:
- DATA_WIDTH, 32, register width; must be a multiple of 8; payload bytes NB = DATA_WIDTH/8.
- NUM_REGS, 4, number of control registers; 1..256.
- HEADER, 8'hA5, frame start byte.
- TIMEOUT_CYCLES, 50000, maximum idle clk cycles between bytes inside a frame; must be ≥2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
- rx_data  in  8  received byte.
- reg_out  out  NUM_REGS*DATA_WIDTH  register bank, flattened; reg i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- sel_ctrl  out  DATA_WIDTH  equal to reg 0; feeds the switch control input.
- wr_pulse  out  1  one-cycle pulse on a successful register write.
- wr_addr  out  8  address of the last successful write; held until the next successful write.
- frame_err  out  1  one-cycle pulse on a rejected frame.

Behaviour:
- Reset values: all registers 0 (so the downstream switch selects its default input), sel_ctrl=0, wr_pulse=0, wr_addr=0, frame_err=0, FSM=IDLE, checksum accumulator=0, byte counter=0.
- Frame format, in order: HEADER, ADDR, D[NB-1]..D[0] (MSB first), CSUM.
- CSUM = (ADDR + sum of all D bytes) mod 256.
- FSM states and transitions (all advance only on rx_valid=1):
  - IDLE: a byte equal to HEADER moves to ADDR. Any other byte is ignored, with no error.
  - ADDR: latch the address, acc=ADDR, cnt=0, move to DATA.
  - DATA: shift the byte into the payload register, acc+=byte (8-bit wrap). When cnt==NB-1, move to CSUM; otherwise cnt++.
  - CSUM: compare the byte to acc, then return to IDLE.
- Accept condition: byte==acc and ADDR<NUM_REGS.
  - On accept: at the sampling edge, reg[ADDR]<=payload and wr_addr<=ADDR. wr_pulse is high for exactly the next cycle.
  - Latency: the register update is visible 1 cycle after the CSUM byte is sampled.
- Reject condition: checksum mismatch OR ADDR≥NUM_REGS.
  - No register changes.
  - frame_err is high for exactly the next cycle.
- A HEADER value appearing inside a frame is treated as ordinary ADDR/DATA/CSUM content; there is no resynchronisation.
- wr_pulse and frame_err are never high in the same cycle.
- rx_valid held high for consecutive cycles means one byte per cycle. Back-to-back frames need no idle gap; a header may immediately follow CSUM.
- Asserting reset mid-frame discards the partial frame and clears all registers.

Optional Feature:
- Macro: HOST_CMD_TIMEOUT_EN.
- Defined:
  - A gap counter clears on every rx_valid and increments each cycle while the FSM is not in IDLE.
  - When the counter reaches TIMEOUT_CYCLES, the FSM returns to IDLE and frame_err pulses for one cycle. Registers are unchanged and the counter clears.
  - If rx_valid arrives in the same cycle as the limit is reached, the byte wins and there is no timeout.
- Not defined: no counter logic exists, and a partial frame waits indefinitely.

Decomposition:
- Shared package: FSM state encoding (IDLE, ADDR, DATA, CSUM), the HEADER default constant, and frame-length constants.
- One natural sub-module: host_cmd_regbank. It holds the NUM_REGS×DATA_WIDTH storage, write enable/address/data, and the flattened output. The FSM stays in host_cmd_decoder.

Test Plan:
- Clean write: send A5 00 00 00 00 01 01. Expect reg0 = 0x00000001, sel_ctrl = 1, wr_pulse high for 1 cycle, wr_addr = 0, frame_err = 0.
- Payload ordering: send A5 02 12 34 56 78 16. Expect reg2 = 0x12345678, and reg0, reg1 and reg3 unchanged.
- Checksum error: send A5 01 00 00 00 02 FF. Expect one frame_err pulse, reg1 unchanged, no wr_pulse.
- Bad address and leading garbage:
  - Send 11 22 A5 05 00 00 00 00 05. Expect frame_err once and no writes.
  - Then send A5 03 AA BB CC DD 11. Expect reg3 = 0xAABBCCDD.
- Timeout (macro defined, TIMEOUT_CYCLES=16):
  - Send A5 00, then 16 idle cycles. Expect frame_err and FSM back in IDLE.
  - Then send A5 00 00 00 00 01 01. Expect reg0 = 1.
  - Without the macro, the same stalled sequence produces no error.
- Reset mid-frame:
  - After reg0 = 1, send A5 00 00 then pulse rst_n low. Expect all registers 0 and sel_ctrl = 0.
  - Then a full frame A5 00 00 00 00 01 01 writes normally.

Source files
------------

// File: rtl/host_cmd_decoder_pkg.sv
// Shared definitions for the host command decoder: FSM state encoding,
// default frame header and frame-length helpers.
package host_cmd_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_CSUM
  } state_t;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  // Header, address and checksum bytes surround the payload.
  localparam int FRAME_OVERHEAD = 3;

  function automatic int payload_bytes(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int frame_bytes(input int data_width);
    return FRAME_OVERHEAD + payload_bytes(data_width);
  endfunction

endpackage

// File: rtl/host_cmd_if.sv
// Byte-stream input and register-bank output bundle of the host command decoder.
interface host_cmd_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 4
);
  logic                           rx_valid;
  logic [7:0]                     rx_data;
  logic [NUM_REGS*DATA_WIDTH-1:0] reg_out;
  logic [DATA_WIDTH-1:0]          sel_ctrl;
  logic                           wr_pulse;
  logic [7:0]                     wr_addr;
  logic                           frame_err;

  modport master (
    output rx_valid, rx_data,
    input  reg_out, sel_ctrl, wr_pulse, wr_addr, frame_err
  );

  modport slave (
    input  rx_valid, rx_data,
    output reg_out, sel_ctrl, wr_pulse, wr_addr, frame_err
  );
endinterface

// File: rtl/host_cmd_regbank.sv
// Control register bank: NUM_REGS x DATA_WIDTH storage with a single write
// port and a flattened read-out (reg i at bits [i*DATA_WIDTH +: DATA_WIDTH]).
module host_cmd_regbank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           we,
  input  logic [7:0]                     waddr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Registers reset to zero so the downstream switch starts on its default input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (waddr == 8'(i)) regs[i] <= wdata;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule

// File: rtl/host_cmd_decoder.sv
// Parses HEADER/ADDR/DATA/CSUM byte frames into the control register bank.
// Optional inter-byte stall timeout enabled by defining HOST_CMD_TIMEOUT_EN.
module host_cmd_decoder
  import host_cmd_decoder_pkg::*;
#(
  parameter int         DATA_WIDTH     = 32,
  parameter int         NUM_REGS       = 4,
  parameter logic [7:0] HEADER         = HEADER_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic     clk,
  input  logic     rst_n,
  host_cmd_if.slave bus
);

  localparam int NB    = payload_bytes(DATA_WIDTH);
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

  if (DATA_WIDTH < 8 || DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a positive multiple of 8");
  end
  if (NUM_REGS < 1 || NUM_REGS > 256) begin : g_bad_regs
    $error("NUM_REGS must be within 1..256");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t                 state;
  logic [7:0]             acc;
  logic [CNT_W-1:0]       cnt;
  logic [7:0]             addr;
  logic [DATA_WIDTH-1:0]  payload;
  logic                   wr_pulse;
  logic                   frame_err;
  logic [7:0]             wr_addr;
  logic                   addr_ok;
  logic                   accept;
  logic                   timeout_hit;
  logic [NUM_REGS*DATA_WIDTH-1:0] reg_flat;

  assign addr_ok = ({1'b0, addr} < 9'(NUM_REGS));
  assign accept  = bus.rx_valid && (state == ST_CSUM) && (bus.rx_data == acc) && addr_ok;

  // Address and payload are pure data; only consulted once the FSM reaches CSUM.
  always_ff @(posedge clk) begin
    if (bus.rx_valid && state == ST_ADDR) addr <= bus.rx_data;
    if (bus.rx_valid && state == ST_DATA) payload <= (payload << 8) | DATA_WIDTH'(bus.rx_data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cnt       <= '0;
      wr_pulse  <= 1'b0;
      frame_err <= 1'b0;
      wr_addr   <= '0;
    end else begin
      wr_pulse  <= 1'b0;
      frame_err <= 1'b0;
      if (bus.rx_valid) begin
        unique case (state)
          ST_IDLE: if (bus.rx_data == HEADER) state <= ST_ADDR;
          ST_ADDR: begin
            acc   <= bus.rx_data;
            cnt   <= '0;
            state <= ST_DATA;
          end
          ST_DATA: begin
            acc <= acc + bus.rx_data;
            if (cnt == CNT_W'(NB - 1)) state <= ST_CSUM;
            else                       cnt   <= cnt + CNT_W'(1);
          end
          ST_CSUM: begin
            state <= ST_IDLE;
            if (accept) begin
              wr_pulse <= 1'b1;
              wr_addr  <= addr;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (timeout_hit) begin
        state     <= ST_IDLE;
        frame_err <= 1'b1;
      end
    end
  end

`ifdef HOST_CMD_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [GAP_W-1:0] gap_cnt;

  // Fires on the idle cycle that would take the count to TIMEOUT_CYCLES; a byte
  // arriving in that same cycle takes precedence.
  assign timeout_hit = !bus.rx_valid && (state != ST_IDLE) &&
                       (gap_cnt == GAP_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                gap_cnt <= '0;
    else if (bus.rx_valid || timeout_hit || state == ST_IDLE) gap_cnt <= '0;
    else                                                       gap_cnt <= gap_cnt + GAP_W'(1);
  end
`else
  assign timeout_hit = 1'b0;
`endif

  host_cmd_regbank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_regbank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (accept),
    .waddr   (addr),
    .wdata   (payload),
    .reg_out (reg_flat)
  );

  assign bus.reg_out   = reg_flat;
  assign bus.sel_ctrl  = reg_flat[DATA_WIDTH-1:0];
  assign bus.wr_pulse  = wr_pulse;
  assign bus.wr_addr   = wr_addr;
  assign bus.frame_err = frame_err;

endmodule
